// File: rtl/axis_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_header_arbiter
// Description : Round-robin arbiter that hands one requester's header to a
//               header inserter, then holds ownership until the inserter's
//               output stream shows the end of the packet.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_header_arbiter #(
  parameter int DATA_WD = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]              req_data,
  input  logic [NUM_REQ*DATA_WD/8-1:0]            req_keep,
  input  logic [NUM_REQ*$clog2(DATA_WD/8)-1:0]    req_byte_cnt,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    valid_insert,
  output logic [DATA_WD-1:0]                      data_insert,
  output logic [DATA_WD/8-1:0]                    keep_insert,
  output logic [$clog2(DATA_WD/8)-1:0]            byte_insert_cnt,
  input  logic                                    ready_insert,
  input  logic                                    valid_out,
  input  logic                                    ready_out,
  input  logic                                    last_out,
  output logic [$clog2(NUM_REQ)-1:0]              grant_id,
  output logic                                    busy
);

  localparam int c_KEEP_WD = DATA_WD / 8;
  localparam int c_CNT_WD  = $clog2(c_KEEP_WD);
  localparam int c_ID_WD   = $clog2(NUM_REQ);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HDR  = 2'd1;
  localparam logic [1:0] c_ST_PKT  = 2'd2;

  localparam logic [c_ID_WD-1:0] c_ID_ONE  = c_ID_WD'(1);
  localparam logic [c_ID_WD-1:0] c_ID_LAST = c_ID_WD'(NUM_REQ - 1);
  localparam logic [c_ID_WD:0]   c_ID_MOD  = (c_ID_WD + 1)'(NUM_REQ);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_ID_WD-1:0]     r_rr_ptr;
  logic [c_ID_WD-1:0]     r_grant_id;
  logic [c_ID_WD-1:0]     w_rr_ptr_nxt;

  logic [2*NUM_REQ-1:0]   w_req_dbl;
  logic [NUM_REQ-1:0]     w_req_rot;
  logic [c_ID_WD-1:0]     w_offset;
  logic [c_ID_WD:0]       w_sum;
  logic                   w_found;
  logic [c_ID_WD-1:0]     w_winner;

  logic                   w_hdr_fire;
  logic                   w_pkt_end;

  // The owner's header is accepted when it is still offered and the inserter takes it.
  assign w_hdr_fire = req_valid[r_grant_id] & ready_insert;
  assign w_pkt_end  = valid_out & ready_out & last_out;

  // Pointer advances past the owner so it becomes lowest priority next round.
  assign w_rr_ptr_nxt = (r_grant_id == c_ID_LAST) ? '0 : (r_grant_id + c_ID_ONE);

  assign grant_id = r_grant_id;

  // Round-robin search: rotate requests so rr_ptr lands on bit 0, take the first set bit.
  always_comb begin
    w_req_dbl = {req_valid, req_valid} >> r_rr_ptr;
    w_req_rot = w_req_dbl[NUM_REQ-1:0];
    w_found   = 1'b0;
    w_offset  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found  = 1'b1;
        w_offset = c_ID_WD'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    if (w_sum >= c_ID_MOD) begin
      w_sum = w_sum - c_ID_MOD;
    end
    w_winner = w_sum[c_ID_WD-1:0];
  end

  // State register plus the grant and round-robin pointer it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_IDLE && w_found) begin
        r_grant_id <= w_winner;
      end
      if (r_state == c_ST_PKT && w_pkt_end) begin
        r_rr_ptr <= w_rr_ptr_nxt;
      end
    end
  end

  // Next-state: grant from IDLE, header handshake ends HDR, packet end ends PKT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_found)    w_state_nxt = c_ST_HDR;
      c_ST_HDR:  if (w_hdr_fire) w_state_nxt = c_ST_PKT;
      c_ST_PKT:  if (w_pkt_end)  w_state_nxt = c_ST_IDLE;
      default:                   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs: only HDR exposes the owner's header; everything else stays quiet.
  always_comb begin
    valid_insert    = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    req_ready       = '0;
    busy            = (r_state != c_ST_IDLE);
    if (r_state == c_ST_HDR) begin
      valid_insert          = req_valid[r_grant_id];
      data_insert           = req_data[int'(r_grant_id)*DATA_WD +: DATA_WD];
      keep_insert           = req_keep[int'(r_grant_id)*c_KEEP_WD +: c_KEEP_WD];
      byte_insert_cnt       = req_byte_cnt[int'(r_grant_id)*c_CNT_WD +: c_CNT_WD];
      req_ready[r_grant_id] = ready_insert;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_header_arbiter
// Description : Scoreboard bench for axis_header_arbiter. The stimulus side
//               predicts each header transfer from a round-robin model and
//               queues it; a monitor compares every observed header handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_header_arbiter;

  localparam int DATA_WD = 32;
  localparam int NUM_REQ = 4;
  localparam int KW      = DATA_WD / 8;
  localparam int CW      = $clog2(KW);
  localparam int IW      = $clog2(NUM_REQ);

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_WD-1:0] req_data;
  logic [NUM_REQ*KW-1:0]     req_keep;
  logic [NUM_REQ*CW-1:0]     req_byte_cnt;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      valid_insert;
  logic [DATA_WD-1:0]        data_insert;
  logic [KW-1:0]             keep_insert;
  logic [CW-1:0]             byte_insert_cnt;
  logic                      ready_insert;
  logic                      valid_out;
  logic                      ready_out;
  logic                      last_out;
  logic [IW-1:0]             grant_id;
  logic                      busy;

  axis_header_arbiter #(.DATA_WD(DATA_WD), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
    .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert), .valid_out(valid_out), .ready_out(ready_out),
    .last_out(last_out), .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    int              id;
    logic [DATA_WD-1:0] d;
    logic [KW-1:0]   k;
    logic [CW-1:0]   c;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  bit                 pend[NUM_REQ];
  logic [DATA_WD-1:0] hdr_data[NUM_REQ];
  logic [KW-1:0]      hdr_keep[NUM_REQ];
  logic [CW-1:0]      hdr_cnt[NUM_REQ];
  int                 model_rr;
  int                 checks;
  int                 failures;
  int                 w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = pend[i];
      req_data[i*DATA_WD +: DATA_WD] = hdr_data[i];
      req_keep[i*KW +: KW]          = hdr_keep[i];
      req_byte_cnt[i*CW +: CW]      = hdr_cnt[i];
    end
  endtask

  task automatic new_req(input int i);
    pend[i]     = 1'b1;
    hdr_data[i] = $urandom;
    hdr_keep[i] = KW'($urandom);
    hdr_cnt[i]  = CW'($urandom);
    drive_reqs();
  endtask

  task automatic fill_all();
    for (int i = 0; i < NUM_REQ; i++) if (!pend[i]) new_req(i);
  endtask

  // Called in IDLE just after an edge; grants on the next edge and runs the header phase.
  task automatic start_packet(input int hdr_stall, input int drop_cycles, output int winner);
    exp_t e;
    winner = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner < 0 && pend[(model_rr + k) % NUM_REQ]) winner = (model_rr + k) % NUM_REQ;
    end
    if (winner < 0) begin
      new_req(model_rr);
      winner = model_rr;
    end
    e.id = winner; e.d = hdr_data[winner]; e.k = hdr_keep[winner]; e.c = hdr_cnt[winner];
    sb.push_back(e);
    ready_insert = 1'b0;
    step();
    check("grant_busy", busy, 1);
    check("grant_id", grant_id, winner);
    check("grant_latency_valid", valid_insert, 1);
    for (int d = 0; d < drop_cycles; d++) begin
      pend[winner] = 1'b0;
      drive_reqs();
      ready_insert = 1'b1;
      #1;
      check("drop_valid_insert", valid_insert, 0);
      step();
      check("drop_busy", busy, 1);
      check("drop_grant_hold", grant_id, winner);
    end
    if (drop_cycles > 0) begin
      pend[winner] = 1'b1;
      ready_insert = 1'b0;
      drive_reqs();
    end
    for (int s = 0; s < hdr_stall; s++) begin
      ready_insert = 1'b0;
      valid_out    = 1'($urandom);
      ready_out    = 1'($urandom);
      last_out     = 1'($urandom);
      #1;
      check("stall_valid_insert", valid_insert, 1);
      check("stall_data_stable", data_insert, hdr_data[winner]);
      check("stall_keep_stable", keep_insert, hdr_keep[winner]);
      step();
      check("stall_busy", busy, 1);
    end
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
    ready_insert = 1'b1;
    step();
    pend[winner] = 1'b0;
    drive_reqs();
    ready_insert = 1'b0;
    #1;
    check("pkt_valid_insert", valid_insert, 0);
    check("pkt_req_ready", req_ready, 0);
    check("pkt_busy", busy, 1);
  endtask

  // Runs the packet body and the ending handshake; returns just after the end edge.
  task automatic finish_packet(input int winner, input int stall, input bit directed);
    for (int s = 0; s < stall; s++) begin
      if (directed) begin
        valid_out = 1'b1; last_out = 1'b1; ready_out = 1'b0;
      end else begin
        valid_out = 1'($urandom);
        last_out  = 1'($urandom);
        ready_out = (valid_out && last_out) ? 1'b0 : 1'($urandom);
      end
      step();
      check("body_busy", busy, 1);
      check("body_grant_hold", grant_id, winner);
    end
    valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
    step();
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
    check("end_idle", busy, 0);
    model_rr = (winner + 1) % NUM_REQ;
  endtask

  // Monitor: invariants every cycle and scoreboard compare on each header handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy !== 1'b1) begin
        check("idle_valid_insert", valid_insert, 0);
        check("idle_req_ready", req_ready, 0);
        check("idle_data_insert", {keep_insert, byte_insert_cnt, data_insert}, 0);
      end else begin
        check("req_ready_owner_only", req_ready & ~(NUM_REQ'(1) << grant_id), 0);
      end
      if (valid_insert === 1'b1 && ready_insert === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_header actual=%0h required=none", data_insert);
        end else begin
          mon_e = sb.pop_front();
          check("hdr_grant", grant_id, mon_e.id);
          check("hdr_data", data_insert, mon_e.d);
          check("hdr_keep", keep_insert, mon_e.k);
          check("hdr_cnt", byte_insert_cnt, mon_e.c);
          check("hdr_req_ready", req_ready, NUM_REQ'(1) << mon_e.id);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; model_rr = 0;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_keep = '0; req_byte_cnt = '0;
    ready_insert = 1'b0; valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; hdr_data[i] = '0; hdr_keep[i] = '0; hdr_cnt[i] = '0;
    end
    #1;
    check("reset_busy", busy, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_outputs", {valid_insert, req_ready, keep_insert, byte_insert_cnt, data_insert}, 0);
    step(); step();
    rst_n = 1'b1;

    // Fairness: every requester always pending, eight packets rotate 0..3 twice.
    for (int p = 0; p < 8; p++) begin
      fill_all();
      start_packet(int'($urandom_range(0, 2)), 0, w);
      check("rr_order", grant_id, p % NUM_REQ);
      finish_packet(w, int'($urandom_range(0, 3)), 1'b0);
    end

    // Single request from requester 2 with a fixed header.
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    pend[2] = 1'b1; hdr_data[2] = 32'hA5A5_0001; hdr_keep[2] = 4'hF; hdr_cnt[2] = 2'd3;
    drive_reqs();
    start_packet(0, 0, w);
    check("single_grant", grant_id, 2);
    finish_packet(w, 3, 1'b0);

    // Spurious end in IDLE: no state change, pointer still at 3.
    valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
    step();
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
    check("spurious_busy", busy, 0);
    fill_all();
    start_packet(1, 0, w);
    check("spurious_rr_kept", grant_id, 3);
    finish_packet(w, 2, 1'b0);

    // Header backpressure for ten cycles.
    fill_all();
    start_packet(10, 0, w);
    finish_packet(w, 2, 1'b0);

    // Packet end stalled by ready_out for fifteen cycles.
    fill_all();
    start_packet(0, 0, w);
    finish_packet(w, 15, 1'b1);
    fill_all();
    start_packet(0, 0, w);
    check("after_stall_next", grant_id, 2);
    finish_packet(w, 1, 1'b0);

    // Owner withdraws its header while in HDR.
    fill_all();
    start_packet(2, 3, w);
    finish_packet(w, 1, 1'b0);

    // Reset in PKT with owner 3, then requesters 1 and 3 compete.
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    drive_reqs();
    new_req(3);
    start_packet(0, 0, w);
    check("pre_reset_grant", grant_id, 3);
    valid_out = 1'b1; ready_out = 1'b0; last_out = 1'b0;
    new_req(1);
    new_req(3);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_outputs", {valid_insert, req_ready, keep_insert, byte_insert_cnt, data_insert}, 0);
    valid_out = 1'b0;
    model_rr = 0;
    step(); step();
    rst_n = 1'b1;
    start_packet(0, 0, w);
    check("post_reset_grant", grant_id, 1);
    finish_packet(w, 2, 1'b0);

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < NUM_REQ; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i);
      start_packet(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 2 : 0, w);
      finish_packet(w, int'($urandom_range(0, 4)), 1'b0);
    end

    step();
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
